// File: rtl/d_ff_reset_if.sv
// d_ff_reset_if: data bundle carried into and out of the register chain.
// The master drives d and observes q; the slave is the register side.
interface d_ff_reset_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (
    output d,
    input  q
  );

  modport slave (
    input  d,
    output q
  );

endinterface

// File: rtl/d_ff_reset.sv
// d_ff_reset: STAGES-deep chain of WIDTH-bit flops, async active-low reset.
// Reset forces every stage to RESET_VAL; q is the last stage's flop.
module d_ff_reset #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              STAGES    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("d_ff_reset: WIDTH=%0d outside 1..64", WIDTH);
  end

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("d_ff_reset: STAGES=%0d outside 1..8", STAGES);
  end

  logic [WIDTH-1:0] stage [STAGES];

  // Shift d one stage per rising edge; no enable, all stages load together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: tb/tb_d_ff_reset.sv
// tb_d_ff_reset: directed vectors for a 1x1 and an 8-bit 3-stage chain.
// Both instances share clk and reset; expected values are hand-derived.
`timescale 1ns/1ps
module tb_d_ff_reset;

  logic clk;
  logic reset;

  int n_vec;
  int n_bad;

  d_ff_reset_if #(.WIDTH(1)) bus_a ();
  d_ff_reset_if #(.WIDTH(8)) bus_b ();

  d_ff_reset #(
    .WIDTH(1),
    .RESET_VAL(1'b0),
    .STAGES(1)
  ) u_a (
    .clk(clk),
    .reset(reset),
    .d(bus_a.d),
    .q(bus_a.q)
  );

  d_ff_reset #(
    .WIDTH(8),
    .RESET_VAL(8'hA5),
    .STAGES(3)
  ) u_b (
    .clk(clk),
    .reset(reset),
    .d(bus_b.d),
    .q(bus_b.q)
  );

  logic       vec_da [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] vec_db [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] exp_qb [6] = '{8'h5A, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus_a.d = 1'b0;
    bus_b.d = 8'h00;

    // assert reset with no clock edge yet
    #1 reset = 1'b0;
    #1;
    check("por_a", 64'(bus_a.q), 64'(1'b0));
    check("por_b", 64'(bus_b.q), 64'(8'hA5));

    // two edges in reset with d=0
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_a", 64'(bus_a.q), 64'(1'b0));
    check("rst_hold_b", 64'(bus_b.q), 64'(8'hA5));

    // d active while reset held low
    bus_a.d = 1'b1;
    bus_b.d = 8'hFF;
    @(posedge clk);
    #1;
    check("rst_d_a", 64'(bus_a.q), 64'(1'b0));
    check("rst_d_b", 64'(bus_b.q), 64'(8'hA5));

    // release reset in the same step as a rising edge
    bus_a.d = 1'b1;
    bus_b.d = 8'h3C;
    @(posedge clk) reset <= 1'b1;
    #1;
    check("rel_edge_a", 64'(bus_a.q), 64'(1'b0));
    check("rel_edge_b", 64'(bus_b.q), 64'(8'hA5));
    @(posedge clk);
    #1;
    check("rel_e1_a", 64'(bus_a.q), 64'(1'b1));
    check("rel_e1_b", 64'(bus_b.q), 64'(8'hA5));
    @(posedge clk);
    #1;
    check("rel_e2_a", 64'(bus_a.q), 64'(1'b1));
    check("rel_e2_b", 64'(bus_b.q), 64'(8'hA5));
    @(posedge clk);
    #1;
    check("rel_e3_a", 64'(bus_a.q), 64'(1'b1));
    check("rel_e3_b", 64'(bus_b.q), 64'(8'h3C));

    // async assertion midway between edges
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_a", 64'(bus_a.q), 64'(1'b0));
    check("async_b", 64'(bus_b.q), 64'(8'hA5));

    // mid-cycle release; first edge loads stage 1
    bus_a.d = 1'b1;
    bus_b.d = 8'h5A;
    #1 reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("mid_rel_a%0d", k), 64'(bus_a.q), 64'(1'b1));
      check($sformatf("mid_rel_b%0d", k), 64'(bus_b.q),
            64'((k == 3) ? 8'h5A : 8'hA5));
    end

    // streaming vectors, d driven on falling edges
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_a.d = vec_da[i];
      bus_b.d = vec_db[i];
      @(posedge clk);
      #1;
      check($sformatf("vec_a%0d", i), 64'(bus_a.q), 64'(vec_da[i]));
      check($sformatf("vec_b%0d", i), 64'(bus_b.q), 64'(exp_qb[i]));
    end

    // d glitches between edges must not reach q
    #1;
    bus_a.d = 1'b1;
    bus_b.d = 8'hFF;
    #2;
    check("glitch_hi_a", 64'(bus_a.q), 64'(1'b0));
    check("glitch_hi_b", 64'(bus_b.q), 64'(8'h44));
    #3;
    check("glitch_fall_a", 64'(bus_a.q), 64'(1'b0));
    check("glitch_fall_b", 64'(bus_b.q), 64'(8'h44));
    bus_a.d = 1'b0;
    bus_b.d = 8'h66;
    @(posedge clk);
    #1;
    check("glitch_edge_a", 64'(bus_a.q), 64'(1'b0));
    check("glitch_edge_b", 64'(bus_b.q), 64'(8'h55));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/d_ff_reset.md
D_FF_RESET -- requirements
Module: d_ff_reset

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits of d and q; legal range 1 to 64.
REQ-002 Parameter RESET_VAL, default all zeros (WIDTH bits), value loaded into q during reset.
REQ-003 Parameter STAGES, default 1, number of cascaded register stages from d to q; legal range 1 to 8.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (reset=0 resets, reset=1 runs).
REQ-006 d  input  WIDTH  data input, sampled on the rising clk edge.
REQ-007 q  output  WIDTH  registered data output, driven directly from the last stage's flop.
REQ-008 Port order SHALL be clk, reset, d, q so positional instantiation works.
REQ-009 Illegal WIDTH or STAGES values SHALL be rejected at elaboration with an error message.

Function
REQ-010 With STAGES=1, q SHALL take the value of d sampled at each rising clk edge while reset=1.
REQ-011 With STAGES=N, d SHALL reach q after exactly N rising edges, one stage per edge.
REQ-012 q SHALL be stable between rising edges; changes on d between edges SHALL NOT affect q.
REQ-013 No combinational path SHALL exist from d or clk to q other than through the flops.
REQ-014 Falling clk edges SHALL have no effect on any state.
REQ-015 The block SHALL have no enable; every rising edge with reset=1 SHALL load all stages.
REQ-016 All bits of q SHALL update together; no bit may update on a different edge.
REQ-017 If the rising clk edge and the release of reset happen in the same time step, the flops SHALL keep RESET_VAL at that edge and SHALL sample d on the next rising edge.

Reset
REQ-018 While reset=0, every stage and q SHALL equal RESET_VAL, whatever clk and d do.
REQ-019 Reset assertion SHALL take effect immediately, with no wait for a clk edge, including during operation.
REQ-020 After reset goes from 0 to 1, the first rising clk edge SHALL load d into stage 1; q SHALL show d after STAGES edges.
REQ-021 At time 0 with reset=0, q SHALL be RESET_VAL and SHALL NOT be X.

Verification
REQ-022 WIDTH=1, STAGES=1: hold reset=0 and d=0 for two clk edges -> q=0 throughout.
REQ-023 WIDTH=1: reset goes 0 to 1 with d=1 -> q=1 after the next rising edge and stays 1 while d=1.
REQ-024 q=1 in normal operation, then reset pulled to 0 midway between edges -> q=0 in the same time step, before any clk edge.
REQ-025 Toggle d 0 to 1 to 0 between two rising edges, with d=0 at the second edge -> q=0 after that edge and unchanged in between.
REQ-026 WIDTH=8, STAGES=3, RESET_VAL=8'hA5: during reset q=8'hA5; after release, drive d=8'h3C -> q=8'h3C on the third rising edge and 8'hA5 before it.
REQ-027 Release reset in the same time step as a rising clk edge with d=1 -> q stays RESET_VAL at that edge and becomes 1 at the following edge.
